// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects the radix-4 datapath; undefined gives radix-2.
package booth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef enum logic [2:0] {
        DIG_ZERO   = 3'd0,
        DIG_PLUS1  = 3'd1,
        DIG_MINUS1 = 3'd2,
        DIG_PLUS2  = 3'd3,
        DIG_MINUS2 = 3'd4
    } booth_digit_t;

`ifdef BOOTH_RADIX4_EN
    localparam bit BOOTH_R4 = 1'b1;
`else
    localparam bit BOOTH_R4 = 1'b0;
`endif

    // One step per recoded digit: the extended multiplier has width+1 (radix-2)
    // or width+2 (radix-4) bits, consumed 1 or 2 bits per step.
    function automatic int booth_iters(input int width, input bit radix4);
        if (radix4) begin
            return width / 2 + 1;
        end else begin
            return width + 1;
        end
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth digit recoder: multiplier window -> digit and signed multiplicand multiple.
// Window is {q1,q0,q-1} when BOOTH_RADIX4_EN is defined, {q0,q-1} otherwise.
module booth_recoder
    import booth_pkg::*;
#(
    parameter int EW = 9
) (
    input  logic [(BOOTH_R4 ? 3 : 2)-1:0] bits,
    input  logic [EW-1:0]                 mcand,
    output booth_digit_t                  digit,
    output logic [EW+1:0]                 multiple
);

    logic [EW+1:0] m_ext_s;
    logic [EW+1:0] neg_s;

    assign m_ext_s = {{2{mcand[EW-1]}}, mcand};
    assign neg_s   = (~m_ext_s) + {{(EW+1){1'b0}}, 1'b1};

    // Window to digit decode.
    always_comb begin
        digit = DIG_ZERO;
`ifdef BOOTH_RADIX4_EN
        case (bits)
            3'b000, 3'b111: digit = DIG_ZERO;
            3'b001, 3'b010: digit = DIG_PLUS1;
            3'b011:         digit = DIG_PLUS2;
            3'b100:         digit = DIG_MINUS2;
            3'b101, 3'b110: digit = DIG_MINUS1;
            default:        digit = DIG_ZERO;
        endcase
`else
        case (bits)
            2'b00, 2'b11: digit = DIG_ZERO;
            2'b01:        digit = DIG_PLUS1;
            2'b10:        digit = DIG_MINUS1;
            default:      digit = DIG_ZERO;
        endcase
`endif
    end

    // Digit to multiplicand multiple, two guard bits wide so 2*M never wraps.
    always_comb begin
        multiple = {(EW+2){1'b0}};
        case (digit)
            DIG_ZERO:   multiple = {(EW+2){1'b0}};
            DIG_PLUS1:  multiple = m_ext_s;
            DIG_MINUS1: multiple = neg_s;
            DIG_PLUS2:  multiple = {m_ext_s[EW:0], 1'b0};
            DIG_MINUS2: multiple = {neg_s[EW:0], 1'b0};
            default:    multiple = {(EW+2){1'b0}};
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with start/ready/done handshake and signed/unsigned mode.
// Define BOOTH_RADIX4_EN for the radix-4 datapath (fewer cycles, same results).
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SH  = BOOTH_R4 ? 2 : 1;
    localparam int EW  = WIDTH + SH;
    localparam int HW  = EW + 2;
    localparam int NIT = booth_iters(WIDTH, BOOTH_R4);
    localparam int CW  = $clog2(NIT + 1);

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_INIT = CW'(NIT);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [EW-1:0]       mcand_r;
    logic [HW-1:0]       hi_r;
    logic [EW-1:0]       lo_r;
    logic                qm1_r;
    logic [2*WIDTH-1:0]  product_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;

    logic [EW-1:0]       a_ext_s;
    logic [EW-1:0]       b_ext_s;
    logic [SH:0]         rec_bits_s;
    booth_digit_t        digit_s;
    logic [HW-1:0]       multiple_s;
    logic [HW-1:0]       sum_s;
    logic signed [HW+EW-1:0] shifted_s;

    // Unsigned operands get zero guard bits so signed recoding still sees a positive value.
    assign a_ext_s    = {{SH{signed_mode & a[WIDTH-1]}}, a};
    assign b_ext_s    = {{SH{signed_mode & b[WIDTH-1]}}, b};
    assign rec_bits_s = {lo_r[SH-1:0], qm1_r};

    booth_recoder #(
        .EW (EW)
    ) u_recoder (
        .bits     (rec_bits_s),
        .mcand    (mcand_r),
        .digit    (digit_s),
        .multiple (multiple_s)
    );

    // Partial-product add on the high half of the accumulator.
    always_comb begin
        if (digit_s == DIG_ZERO) begin
            sum_s = hi_r;
        end else begin
            sum_s = hi_r + multiple_s;
        end
    end

    assign shifted_s = $signed({sum_s, lo_r}) >>> SH;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture, Booth iteration and result latch on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {EW{1'b0}};
            hi_r      <= {HW{1'b0}};
            lo_r      <= {EW{1'b0}};
            qm1_r     <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r <= a_ext_s;
                        lo_r    <= b_ext_s;
                        hi_r    <= {HW{1'b0}};
                        qm1_r   <= 1'b0;
                        cnt_r   <= CNT_INIT;
                    end
                end
                ST_RUN: begin
                    hi_r  <= shifted_s[HW+EW-1:EW];
                    lo_r  <= shifted_s[EW-1:0];
                    qm1_r <= lo_r[SH-1];
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        product_r <= shifted_s[2*WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
